// File: rtl/afifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write and read side).
// The Gray conversions work on zero-extended 32-bit values, so one function serves every pointer width.
package afifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits propagate as zero, so a narrower pointer converts correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Binary + Gray pointer counter with one wrap bit; used by both FIFO pointer domains.
// The Gray value is registered directly so it can feed a synchroniser without glue logic.
module gray_ptr_cnt
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [ADDR_WIDTH:0] bin,
    output logic [ADDR_WIDTH:0] gray,
    output logic [ADDR_WIDTH:0] bin_next,
    output logic [ADDR_WIDTH:0] gray_next
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    assign bin_next  = bin + PTR_W'(inc);
    assign gray_next = PTR_W'(bin2gray(GRAY_MAX_W'(bin_next)));

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag manager for the async FIFO: write pointer, RAM strobe/address,
// full, almost_full, occupancy estimate and sticky overflow, all on clk.
module fifo_wptr_full
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    input  logic                  overflow_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int A     = ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic             push;
    logic [A:0]       wbin;
    logic [A:0]       wbin_next;
    logic [A:0]       wgray_next;
    logic [A:0]       rbin_sync;
    logic [A:0]       level_next;
    logic [A:0]       full_pattern;

    // Reset gates the strobe so a write in flight when reset hits never reaches the RAM.
    assign push      = wr_en & ~full & ~reset;
    assign wr_accept = push;
    assign waddr     = wbin[A-1:0];

    gray_ptr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wptr (
        .clk       (clk),
        .reset     (reset),
        .inc       (push),
        .bin       (wbin),
        .gray      (wptr_gray),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_pattern = {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]};
    assign rbin_sync    = PTR_W'(gray2bin(GRAY_MAX_W'(rptr_gray_sync)));
    assign level_next   = wbin_next - rbin_sync;

    // NOTE: reset here is synchronous, so it appears only inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            full        <= (wgray_next == full_pattern);
            almost_full <= (level_next >= PTR_W'(AFULL_THRESH));
            wr_level    <= level_next;
        end
    end

    // Set has priority over clear so a rejected write is never lost from the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=4, AFULL_THRESH=12) with a small write/read model
// for the random-drain phase; inputs change and outputs are sampled 1 ns after the rising edge.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [4:0] rptr_gray_sync;
    logic       overflow_clr;
    logic       wr_accept;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    fifo_wptr_full #(
        .ADDR_WIDTH   (4),
        .AFULL_THRESH (12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .overflow_clr   (overflow_clr),
        .wr_accept      (wr_accept),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .wr_level       (wr_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] wb_m;
    logic [4:0] rb_m;
    logic [4:0] lvl_m;
    logic       full_m;
    logic [4:0] prev_gray;
    logic [3:0] prev_waddr;
    logic       seen_gray_wrap;
    logic       seen_waddr_wrap;
    int         pushes;

    initial begin
        reset          = 1'b1;
        wr_en          = 1'b1;
        rptr_gray_sync = 5'd0;
        overflow_clr   = 1'b0;

        // 1. Reset held three cycles with wr_en high.
        repeat (3) tick();
        check("rst_wptr_gray", 32'(wptr_gray), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_wr_level", 32'(wr_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wr_accept", 32'(wr_accept), 32'd0);

        // 2. Sixteen pushes with the read pointer parked at 0.
        reset = 1'b0;
        #1;
        check("fill_accept_first", 32'(wr_accept), 32'd1);
        check("fill_waddr_first", 32'(waddr), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check("fill_level", 32'(wr_level), 32'(k));
            check("fill_almost_full", 32'(almost_full), (k >= 12) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (k == 16) ? 32'd1 : 32'd0);
        end
        check("fill_wptr_gray", 32'(wptr_gray), 32'b11000);

        // 3. Writes while full are rejected and set overflow; set beats clear.
        check("ovf_accept", 32'(wr_accept), 32'd0);
        tick();
        check("ovf_waddr_hold", 32'(waddr), 32'd0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_gray_hold", 32'(wptr_gray), 32'b11000);
        tick();
        check("ovf_accept_2", 32'(wr_accept), 32'd0);
        overflow_clr = 1'b1;
        tick();
        check("ovf_clr_with_wr", 32'(overflow), 32'd1);
        wr_en = 1'b0;
        tick();
        check("ovf_clr_alone", 32'(overflow), 32'd0);
        overflow_clr = 1'b0;

        // 4. Read pointer advances to 4, then 6.
        rptr_gray_sync = 5'b00110;
        tick();
        check("rd4_full", 32'(full), 32'd0);
        check("rd4_level", 32'(wr_level), 32'd12);
        check("rd4_almost_full", 32'(almost_full), 32'd1);
        rptr_gray_sync = 5'b00101;
        tick();
        check("rd6_level", 32'(wr_level), 32'd10);
        check("rd6_almost_full", 32'(almost_full), 32'd0);
        check("rd6_full", 32'(full), 32'd0);

        // 5. 100 pushes against a randomly draining read side.
        wb_m            = 5'd16;
        rb_m            = 5'd6;
        full_m          = 1'b0;
        pushes          = 0;
        seen_gray_wrap  = 1'b0;
        seen_waddr_wrap = 1'b0;
        for (int cyc = 0; cyc < 1000 && pushes < 100; cyc++) begin
            rptr_gray_sync = rb_m ^ (rb_m >> 1);
            wr_en          = 1'b1;
            #1;
            check("rnd_accept", 32'(wr_accept), full_m ? 32'd0 : 32'd1);
            check("rnd_waddr", 32'(waddr), 32'(wb_m[3:0]));
            prev_gray  = wptr_gray;
            prev_waddr = waddr;
            @(posedge clk);
            #1;
            if (!full_m) begin
                wb_m = wb_m + 5'd1;
                pushes++;
            end
            lvl_m  = wb_m - rb_m;
            full_m = (lvl_m == 5'd16);
            check("rnd_gray", 32'(wptr_gray), 32'(wb_m ^ (wb_m >> 1)));
            check("rnd_hamming", ($countones(prev_gray ^ wptr_gray) <= 1) ? 32'd1 : 32'd0, 32'd1);
            check("rnd_level", 32'(wr_level), 32'(lvl_m));
            check("rnd_full", 32'(full), 32'(full_m));
            check("rnd_almost_full", 32'(almost_full), (lvl_m >= 5'd12) ? 32'd1 : 32'd0);
            if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) seen_gray_wrap = 1'b1;
            if (prev_waddr == 4'd15 && waddr == 4'd0) seen_waddr_wrap = 1'b1;
            if (lvl_m != 5'd0 && $urandom_range(0, 9) < 4) rb_m = rb_m + 5'd1;
        end
        check("rnd_push_count", 32'(pushes), 32'd100);
        check("rnd_gray_wrap_seen", 32'(seen_gray_wrap), 32'd1);
        check("rnd_waddr_wrap_seen", 32'(seen_waddr_wrap), 32'd1);

        // 6. Reset after seven pushes with wr_en still high.
        reset = 1'b1;
        wr_en = 1'b0;
        tick();
        reset          = 1'b0;
        rptr_gray_sync = 5'd0;
        wr_en          = 1'b1;
        repeat (7) tick();
        check("pre_rst_waddr", 32'(waddr), 32'd7);
        check("pre_rst_level", 32'(wr_level), 32'd7);
        reset = 1'b1;
        #1;
        check("mid_rst_accept", 32'(wr_accept), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_gray", 32'(wptr_gray), 32'd0);
        check("mid_rst_waddr", 32'(waddr), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_almost_full", 32'(almost_full), 32'd0);
        check("mid_rst_level", 32'(wr_level), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_accept", 32'(wr_accept), 32'd1);
        check("post_rst_waddr", 32'(waddr), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_gray", 32'(wptr_gray), 32'd1);
        check("post_rst_level", 32'(wr_level), 32'd1);
        wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
